// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// Opcodes, state encodings, mux select encodings and the control word.
package mips_ctrl_pkg;

    localparam int OPC_W = 6;

    // Instruction opcodes (instruction bits 31:26)
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

    // Controller states; codes 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    // ALU operand B select
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_SEXT    = 2'b10;
    localparam logic [1:0] ALUSRCB_SEXT_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU control class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Full set of datapath selects and enables for one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure combinational state -> control word decoder.
// Only FETCH looks at the (reset-qualified) memory ready strobe.
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Moore decode: every field defaults to 0, each state sets its own
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ALUSRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.ir_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ALUSRCB_SEXT_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Holds the state register and next-state logic; outputs come from the decoder.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic [ST_W-1:0] State,
    output logic            Illegal
);

    localparam logic [OP_W-1:0] C_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] C_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] C_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] C_BEQ   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] C_J     = OP_W'(OP_J);
    localparam logic [OP_W-1:0] C_ADDI  = OP_W'(OP_ADDI);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   ready_q;
    ctrl_t  ctrl;

    // A held reset masks MemReady so FETCH cannot load PC/IR under reset
    assign ready_q = MemReady & ~reset;

    // Next state; Op is only looked at in DECODE and MEMADR
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (Op == C_LW || Op == C_SW) begin
                    state_d = S_MEMADR;
                end else if (Op == C_RTYPE) begin
                    state_d = S_EXEC;
                end else if (Op == C_BEQ) begin
                    state_d = S_BRANCH;
                end else if (Op == C_J) begin
                    state_d = S_JUMP;
                end else if (Op == C_ADDI) begin
                    state_d = S_IEXEC;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                if (Op == C_LW) begin
                    state_d = S_MEMRD;
                end else if (Op == C_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMRD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register and registered Illegal pulse, async reset to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    ctrl_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (ready_q),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign State       = ST_W'(state_q);
    assign Illegal     = illegal_q;

endmodule
